// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display controller: converts a binary value to BCD
// (sequential double-dabble) or hex nibbles, holds it, and scans DIGITS digits.
module seg7_scan_ctrl #(
    parameter int DIGITS        = 4,
    parameter int DATA_W        = 32,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic              clk_pre,
    input  logic              reset,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    input  logic              hex_mode,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WIDE_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int ITER_W = $clog2(DATA_W + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W  = $clog2(REFRESH_DIV);

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t              state_reg;
    logic [DATA_W-1:0]   val_reg;
    logic                hex_reg;
    logic [BCD_W-1:0]    bcd_reg;
    logic                ovf_sticky_reg;
    logic [ITER_W-1:0]   iter_reg;
    logic [BCD_W-1:0]    disp_reg;
    logic                ovf_reg;
    logic                busy_reg;

    logic [REF_W-1:0]    refresh_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [DIGITS-1:0]   an_reg;
    logic [6:0]          seg_reg;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shift;
    logic                shift_carry;
    logic [WIDE_W-1:0]   val_ext;
    logic [BCD_W-1:0]    hex_digits;
    logic                hex_ovf;

    logic [DIGITS-1:0]   digit_zero;
    logic [DIGITS-1:0]   zero_above;
    logic [6:0]          glyph [DIGITS];
    logic [6:0]          seg_next;

    function automatic logic [6:0] glyph_of(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'ha: g = 7'b0001000;
            4'hb: g = 7'b1100000;
            4'hc: g = 7'b0110001;
            4'hd: g = 7'b1000010;
            4'he: g = 7'b0110000;
            4'hf: g = 7'b0111000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                        ? bcd_reg[4*gi +: 4] + 4'd3
                                        : bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign shift_carry = bcd_adj[BCD_W-1];
    assign bcd_shift   = {bcd_adj[BCD_W-2:0], val_reg[DATA_W-1]};

    assign val_ext    = WIDE_W'(val_reg);
    assign hex_digits = val_ext[BCD_W-1:0];
    assign hex_ovf    = |(val_ext >> BCD_W);

    always_ff @(posedge clk_pre) begin
        if (reset) begin
            state_reg      <= IDLE;
            val_reg        <= '0;
            hex_reg        <= 1'b0;
            bcd_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
            iter_reg       <= '0;
            disp_reg       <= '0;
            ovf_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        val_reg        <= value;
                        hex_reg        <= hex_mode;
                        bcd_reg        <= '0;
                        ovf_sticky_reg <= 1'b0;
                        iter_reg       <= ITER_W'(DATA_W);
                        busy_reg       <= 1'b1;
                        state_reg      <= hex_mode ? COMMIT : SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg        <= bcd_shift;
                    val_reg        <= val_reg << 1;
                    ovf_sticky_reg <= ovf_sticky_reg | shift_carry;
                    iter_reg       <= iter_reg - ITER_W'(1);
                    if (iter_reg == ITER_W'(1)) begin
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_reg  <= hex_reg ? hex_digits : bcd_reg;
                    ovf_reg   <= hex_reg ? hex_ovf : ovf_sticky_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A digit above position 0 is leading iff it and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_glyph
            assign digit_zero[gi] = (disp_reg[4*gi +: 4] == 4'h0);
            if (gi == DIGITS - 1) begin : g_top
                assign zero_above[gi] = digit_zero[gi];
            end else begin : g_mid
                assign zero_above[gi] = digit_zero[gi] & zero_above[gi+1];
            end
            if (gi == 0 || BLANK_LEADING == 0) begin : g_noblank
                assign glyph[gi] = ovf_reg ? SEG_DASH : glyph_of(disp_reg[4*gi +: 4]);
            end else begin : g_blank
                assign glyph[gi] = ovf_reg        ? SEG_DASH  :
                                   zero_above[gi] ? SEG_BLANK :
                                   glyph_of(disp_reg[4*gi +: 4]);
            end
        end
    endgenerate

    assign seg_next = glyph[idx_reg];

    always_ff @(posedge clk_pre) begin
        if (reset) begin
            refresh_reg <= '0;
            idx_reg     <= '0;
            an_reg      <= '1;
            seg_reg     <= SEG_BLANK;
        end else begin
            if (refresh_reg == REF_W'(REFRESH_DIV - 1)) begin
                refresh_reg <= '0;
                idx_reg     <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
            end else begin
                refresh_reg <= refresh_reg + REF_W'(1);
            end
            an_reg  <= ~(DIGITS'(1) << idx_reg);
            seg_reg <= seg_next;
        end
    end

    assign busy     = busy_reg;
    assign overflow = ovf_reg;
    assign an       = an_reg;
    assign seg      = seg_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: two instances (leading-zero blanking on/off)
// share all inputs; expected glyphs are hand-written constants.
module tb_seg7_scan_ctrl;

    localparam logic [6:0] G0   = 7'b0000001;
    localparam logic [6:0] G5   = 7'b0100100;
    localparam logic [6:0] G7   = 7'b0001111;
    localparam logic [6:0] G9   = 7'b0000100;
    localparam logic [6:0] GB   = 7'b1100000;
    localparam logic [6:0] GE   = 7'b0110000;
    localparam logic [6:0] GF   = 7'b0111000;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] BL   = 7'b1111111;

    logic        clk_pre = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        load;
    logic        hex_mode;
    logic        busy_a, overflow_a, busy_b, overflow_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;

    int total  = 0;
    int passed = 0;
    int n;

    logic [6:0] seen_a [4];
    logic [6:0] seen_b [4];
    int         dwell  [4];
    int         bad_an;

    seg7_scan_ctrl #(.DIGITS(4), .DATA_W(32), .REFRESH_DIV(4), .BLANK_LEADING(1)) dut_a (
        .clk_pre(clk_pre), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
        .busy(busy_a), .overflow(overflow_a), .an(an_a), .seg(seg_a)
    );

    seg7_scan_ctrl #(.DIGITS(4), .DATA_W(32), .REFRESH_DIV(4), .BLANK_LEADING(0)) dut_b (
        .clk_pre(clk_pre), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
        .busy(busy_b), .overflow(overflow_b), .an(an_b), .seg(seg_b)
    );

    always #5 clk_pre = ~clk_pre;

    task automatic tick();
        @(posedge clk_pre);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept a load, then count cycles until busy drops (bounded).
    task automatic do_load(input logic [31:0] v, input logic hm, output int cycles);
        value    = v;
        hex_mode = hm;
        load     = 1'b1;
        tick();
        load   = 1'b0;
        cycles = 0;
        while (busy_a && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    // Record what each digit shows over two full frames.
    task automatic capture();
        logic [3:0] pat;
        logic       hit;
        for (int k = 0; k < 4; k++) begin
            seen_a[k] = 'x;
            seen_b[k] = 'x;
            dwell[k]  = 0;
        end
        bad_an = 0;
        tick();
        tick();
        for (int c = 0; c < 32; c++) begin
            hit = 1'b0;
            for (int k = 0; k < 4; k++) begin
                pat = ~(4'b0001 << k);
                if (an_a == pat) begin
                    seen_a[k] = seg_a;
                    dwell[k]++;
                    hit = 1'b1;
                end
                if (an_b == pat) seen_b[k] = seg_b;
            end
            if (!hit) bad_an++;
            tick();
        end
    endtask

    task automatic check_disp(input string tag, input logic [27:0] ea, input logic [27:0] eb);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_blank_d%0d", tag, k), 32'(seen_a[k]), 32'(ea[7*k +: 7]));
            chk($sformatf("%s_noblank_d%0d", tag, k), 32'(seen_b[k]), 32'(eb[7*k +: 7]));
        end
    endtask

    task automatic check_scan(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_dwell_d%0d", tag, k), 32'(dwell[k]), 32'd8);
        end
        chk($sformatf("%s_an_onehot", tag), 32'(bad_an), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value    = '0;
        hex_mode = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_an", 32'(an_a), 32'hF);
        chk("rst_seg", 32'(seg_a), 32'(BL));
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovf", 32'(overflow_a), 32'd0);
        reset = 1'b0;
        tick();
        chk("first_an", 32'(an_a), 32'b1110);
        chk("first_seg", 32'(seg_a), 32'(G0));
        capture();
        check_disp("rst", {BL, BL, BL, G0}, {G0, G0, G0, G0});
        check_scan("rst");

        // Decimal 5050
        do_load(32'd5050, 1'b0, n);
        chk("dec5050_busy", 32'(n), 32'd33);
        chk("dec5050_ovf", 32'(overflow_a), 32'd0);
        capture();
        check_disp("dec5050", {G5, G0, G5, G0}, {G5, G0, G5, G0});
        check_scan("dec5050");

        // Blanking with a single-digit value
        do_load(32'd7, 1'b0, n);
        chk("dec7_busy", 32'(n), 32'd33);
        capture();
        check_disp("dec7", {BL, BL, BL, G7}, {G0, G0, G0, G7});

        // Overflow, then recovery at the largest 4-digit value
        do_load(32'd12345, 1'b0, n);
        chk("dec12345_ovf", 32'(overflow_a), 32'd1);
        capture();
        check_disp("dec12345", {DASH, DASH, DASH, DASH}, {DASH, DASH, DASH, DASH});
        do_load(32'd9999, 1'b0, n);
        chk("dec9999_ovf", 32'(overflow_a), 32'd0);
        capture();
        check_disp("dec9999", {G9, G9, G9, G9}, {G9, G9, G9, G9});

        // Hex
        do_load(32'hBEEF, 1'b1, n);
        chk("hexbeef_busy", 32'(n), 32'd1);
        chk("hexbeef_ovf", 32'(overflow_a), 32'd0);
        capture();
        check_disp("hexbeef", {GB, GE, GE, GF}, {GB, GE, GE, GF});
        do_load(32'h1BEEF, 1'b1, n);
        chk("hex1beef_ovf", 32'(overflow_a), 32'd1);
        capture();
        check_disp("hex1beef", {DASH, DASH, DASH, DASH}, {DASH, DASH, DASH, DASH});

        // Load while busy is ignored
        value    = 32'd5050;
        hex_mode = 1'b0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        value = 32'd42;
        load  = 1'b1;
        tick();
        load = 1'b0;
        n    = 0;
        while (busy_a && n < 200) begin
            tick();
            n++;
        end
        chk("ignored_load_busy", 32'(n), 32'd27);
        chk("ignored_load_ovf", 32'(overflow_a), 32'd0);
        capture();
        check_disp("ignored_load", {G5, G0, G5, G0}, {G5, G0, G5, G0});

        // Reset at shift iteration 10 abandons the conversion
        value = 32'd5050;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("midconv_busy_before", 32'(busy_a), 32'd1);
        reset = 1'b1;
        tick();
        chk("midconv_busy", 32'(busy_a), 32'd0);
        chk("midconv_an", 32'(an_a), 32'hF);
        chk("midconv_seg", 32'(seg_a), 32'(BL));
        reset = 1'b0;
        tick();
        chk("midconv_first_an", 32'(an_a), 32'b1110);
        chk("midconv_first_seg", 32'(seg_a), 32'(G0));
        chk("midconv_ovf", 32'(overflow_a), 32'd0);
        capture();
        check_disp("midconv", {BL, BL, BL, G0}, {G0, G0, G0, G0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
